// File: rtl/modadd_issue_ctrl.sv
// Issue controller for the combinational modular adder/subtractor: queues commands,
// normalises operands, drives one operation at a time and holds its result for the consumer.
module modadd_issue_ctrl #(
    parameter int WIDTH      = 4,
    parameter int MOD        = 15,
    parameter int FIFO_DEPTH = 4,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_s,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    output logic             op_s,
    output logic [WIDTH-1:0] op_x,
    output logic [WIDTH-1:0] op_y,
    input  logic [WIDTH-1:0] op_z,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_z,
    output logic             out_s,
    output logic [LW-1:0]    level
);

    localparam logic [WIDTH-1:0] MOD_W = WIDTH'(MOD);
    localparam int               EW    = 2 * WIDTH + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]      level_q, level_d;
    logic               op_s_q, op_s_d;
    logic [WIDTH-1:0]   op_x_q, op_x_d, op_y_q, op_y_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_z_q, out_z_d;
    logic               out_s_q, out_s_d;

    logic [EW-1:0]      mem [FIFO_DEPTH];
    logic [EW-1:0]      head;
    logic               push, pop, load_out, clr_out;

    // Operands at or above MOD are folded back into range exactly once.
    function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] v);
        return (v >= MOD_W) ? v - MOD_W : v;
    endfunction

    assign in_ready = (level_q != LW'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_s, norm(in_x), norm(in_y)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (level_q != '0) state_d = SETTLE;
            SETTLE:  state_d = HOLD;
            HOLD:    if (out_ready) state_d = (level_q != '0) ? SETTLE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop      = 1'b0;
        load_out = 1'b0;
        clr_out  = 1'b0;
        case (state_q)
            IDLE:    pop = (level_q != '0);
            SETTLE:  load_out = 1'b1;
            HOLD: begin
                clr_out = out_ready;
                pop     = out_ready && (level_q != '0);
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d     = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        op_s_d      = pop ? head[EW-1] : op_s_q;
        op_x_d      = pop ? head[2*WIDTH-1:WIDTH] : op_x_q;
        op_y_d      = pop ? head[WIDTH-1:0] : op_y_q;
        out_valid_d = load_out ? 1'b1 : (clr_out ? 1'b0 : out_valid_q);
        out_z_d     = load_out ? op_z : out_z_q;
        out_s_d     = load_out ? op_s_q : out_s_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            op_s_q      <= 1'b0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
            out_s_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            op_s_q      <= op_s_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
            out_s_q     <= out_s_d;
        end
    end

    assign op_s      = op_s_q;
    assign op_x      = op_x_q;
    assign op_y      = op_y_q;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;
    assign out_s     = out_s_q;
    assign level     = level_q;

endmodule
